// File: rtl/window_buffer_5x5.sv
// 5x5 sliding window over a raster pixel stream using four line buffers.
// Optional last-pixel pulse o_frame_done is built only when WINDOW_BUFFER_FRAME_DONE_EN is defined.
module window_buffer_5x5 #(
  parameter int WIDTH      = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic [WIDTH-1:0] i_pixel,
  output logic [WIDTH-1:0] o_pixel_00, o_pixel_01, o_pixel_02, o_pixel_03, o_pixel_04,
  output logic [WIDTH-1:0] o_pixel_10, o_pixel_11, o_pixel_12, o_pixel_13, o_pixel_14,
  output logic [WIDTH-1:0] o_pixel_20, o_pixel_21, o_pixel_22, o_pixel_23, o_pixel_24,
  output logic [WIDTH-1:0] o_pixel_30, o_pixel_31, o_pixel_32, o_pixel_33, o_pixel_34,
  output logic [WIDTH-1:0] o_pixel_40, o_pixel_41, o_pixel_42, o_pixel_43, o_pixel_44,
  output logic             o_enable_5x5
`ifdef WINDOW_BUFFER_FRAME_DONE_EN
  ,
  output logic             o_frame_done
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FILL  = RW'(3);
  localparam logic [RW-1:0] ROW_WIN   = RW'(4);
  localparam logic [CW-1:0] COL_WIN   = CW'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                       state_r, state_next_s;
  logic [CW-1:0]                col_r, col_eff_s, col_next_s;
  logic [RW-1:0]                row_r, row_eff_s, row_next_s;
  logic                         col_last_s, row_last_s, win_en_s;
  logic [WIDTH-1:0]             lb_mem [4][IMG_WIDTH];
  logic [3:0][WIDTH-1:0]        lb_rd_s;
  logic [4:0][4:0][WIDTH-1:0]   win_r;
  logic                         enable_r;

  // Effective position: start-of-frame forces (0,0) regardless of the counters.
  always_comb begin
    if (i_sof) begin
      col_eff_s = '0;
      row_eff_s = '0;
    end else begin
      col_eff_s = col_r;
      row_eff_s = row_r;
    end
    col_last_s = (col_eff_s == COL_LAST);
    row_last_s = (row_eff_s == ROW_LAST);
    if (col_last_s) begin
      col_next_s = '0;
      if (row_last_s) begin
        row_next_s = '0;
      end else begin
        row_next_s = row_eff_s + RW'(1);
      end
    end else begin
      col_next_s = col_eff_s + CW'(1);
      row_next_s = row_eff_s;
    end
  end

  // Line-buffer read ports; lb_rd_s[k] is the pixel k+1 rows above at this column.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lb_rd_s[k] = lb_mem[k][col_eff_s];
    end
  end

  // Next-state logic and window-complete decision.
  always_comb begin
    state_next_s = state_r;
    win_en_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (i_valid) begin
          state_next_s = S_FILL;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_FILL: begin
        if (i_valid && !i_sof && (row_eff_s == ROW_FILL) && col_last_s) begin
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_FILL;
        end
      end
      S_RUN: begin
        if (i_valid && (i_sof || (row_last_s && col_last_s))) begin
          state_next_s = S_FILL;
        end else begin
          state_next_s = S_RUN;
        end
        win_en_s = i_valid && (row_eff_s >= ROW_WIN) && (col_eff_s >= COL_WIN);
      end
      default: begin
        state_next_s = S_IDLE;
        win_en_s     = 1'b0;
      end
    endcase
  end

  // State, counters, window shift register and enable pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= S_IDLE;
      col_r    <= '0;
      row_r    <= '0;
      win_r    <= '0;
      enable_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      enable_r <= win_en_s;
      if (i_valid) begin
        col_r <= col_next_s;
        row_r <= row_next_s;
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) begin
            win_r[r][c] <= win_r[r][c+1];
          end
        end
        for (int r = 0; r < 4; r++) begin
          win_r[r][4] <= lb_rd_s[3-r];
        end
        win_r[4][4] <= i_pixel;
      end
    end
  end

  // Line buffers cascade one row deeper per accepted pixel; contents are never reset.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      lb_mem[0][col_eff_s] <= i_pixel;
      for (int k = 1; k < 4; k++) begin
        lb_mem[k][col_eff_s] <= lb_rd_s[k-1];
      end
    end
  end

`ifdef WINDOW_BUFFER_FRAME_DONE_EN
  logic frame_done_r;

  // Pulse alongside the enable of the window ending at the frame's last pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= win_en_s && row_last_s && col_last_s;
    end
  end

  assign o_frame_done = frame_done_r;
`endif

  assign o_enable_5x5 = enable_r;
  assign o_pixel_00 = win_r[0][0];
  assign o_pixel_01 = win_r[0][1];
  assign o_pixel_02 = win_r[0][2];
  assign o_pixel_03 = win_r[0][3];
  assign o_pixel_04 = win_r[0][4];
  assign o_pixel_10 = win_r[1][0];
  assign o_pixel_11 = win_r[1][1];
  assign o_pixel_12 = win_r[1][2];
  assign o_pixel_13 = win_r[1][3];
  assign o_pixel_14 = win_r[1][4];
  assign o_pixel_20 = win_r[2][0];
  assign o_pixel_21 = win_r[2][1];
  assign o_pixel_22 = win_r[2][2];
  assign o_pixel_23 = win_r[2][3];
  assign o_pixel_24 = win_r[2][4];
  assign o_pixel_30 = win_r[3][0];
  assign o_pixel_31 = win_r[3][1];
  assign o_pixel_32 = win_r[3][2];
  assign o_pixel_33 = win_r[3][3];
  assign o_pixel_34 = win_r[3][4];
  assign o_pixel_40 = win_r[4][0];
  assign o_pixel_41 = win_r[4][1];
  assign o_pixel_42 = win_r[4][2];
  assign o_pixel_43 = win_r[4][3];
  assign o_pixel_44 = win_r[4][4];

endmodule

// File: tb/tb_window_buffer_5x5.sv
// Scoreboard bench for window_buffer_5x5 on an 8x8 image.
module tb_window_buffer_5x5;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_sof = 1'b0;
  logic [7:0]       i_pixel = 8'h00;
  logic [24:0][7:0] pw;
  logic             o_enable_5x5;
  logic             o_frame_done;

  typedef struct packed {
    logic [3:0]       r;
    logic [3:0]       c;
    logic             fd;
    logic [24:0][7:0] w;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   en_seen = 0;

  window_buffer_5x5 #(.WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_pixel(i_pixel),
    .o_pixel_00(pw[0]),  .o_pixel_01(pw[1]),  .o_pixel_02(pw[2]),  .o_pixel_03(pw[3]),  .o_pixel_04(pw[4]),
    .o_pixel_10(pw[5]),  .o_pixel_11(pw[6]),  .o_pixel_12(pw[7]),  .o_pixel_13(pw[8]),  .o_pixel_14(pw[9]),
    .o_pixel_20(pw[10]), .o_pixel_21(pw[11]), .o_pixel_22(pw[12]), .o_pixel_23(pw[13]), .o_pixel_24(pw[14]),
    .o_pixel_30(pw[15]), .o_pixel_31(pw[16]), .o_pixel_32(pw[17]), .o_pixel_33(pw[18]), .o_pixel_34(pw[19]),
    .o_pixel_40(pw[20]), .o_pixel_41(pw[21]), .o_pixel_42(pw[22]), .o_pixel_43(pw[23]), .o_pixel_44(pw[24]),
    .o_enable_5x5(o_enable_5x5)
`ifdef WINDOW_BUFFER_FRAME_DONE_EN
    , .o_frame_done(o_frame_done)
`endif
  );

`ifndef WINDOW_BUFFER_FRAME_DONE_EN
  assign o_frame_done = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] pix(input int r, input int c, input int off);
    return 8'((r * 8 + c + off) & 255);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every enable must match the oldest pending expected window.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n && o_enable_5x5) begin
      en_seen++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_enable got window %h expected no enable", pw);
      end else begin
        e = q.pop_front();
        if (pw !== e.w) begin
          errors++;
          $display("FAIL window_r%0d_c%0d got %h expected %h", e.r, e.c, pw, e.w);
        end
`ifdef WINDOW_BUFFER_FRAME_DONE_EN
        checks++;
        if (o_frame_done !== e.fd) begin
          errors++;
          $display("FAIL frame_done_r%0d_c%0d got %0b expected %0b", e.r, e.c, o_frame_done, e.fd);
        end
`endif
      end
    end
`ifdef WINDOW_BUFFER_FRAME_DONE_EN
    if (i_rst_n && o_frame_done && !o_enable_5x5) begin
      checks++;
      errors++;
      $display("FAIL frame_done_alone got 1 expected 0");
    end
`endif
  end

  task automatic send(input int r, input int c, input bit sof, input int off);
    exp_t e;
    i_valid = 1'b1;
    i_sof   = sof;
    i_pixel = pix(r, c, off);
    if (r >= 4 && c >= 4) begin
      e.r  = 4'(r);
      e.c  = 4'(c);
      e.fd = (r == 7 && c == 7);
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          e.w[i*5+j] = pix(r - 4 + i, c - 4 + j, off);
      q.push_back(e);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_sof   = 1'b1;
    i_pixel = 8'hFF;
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
      chk("idle_enable", int'(o_enable_5x5), 0);
    end
    i_sof = 1'b0;
  endtask

  // hand: 1 = first-window and last-window constants, 2 = gap before (5,6)
  task automatic frame(input int off, input bit sof, input int npix, input int hand);
    int r, c;
    for (int k = 0; k < npix; k++) begin
      r = k / 8;
      c = k % 8;
      if (hand == 2 && r == 5 && c == 6) idle(3);
      send(r, c, sof && (k == 0), off);
      if (hand == 1 && r == 4 && c == 4) begin
        chk("first_en", int'(o_enable_5x5), 1);
        chk("first_p00", int'(pw[0]), 8'h00);
        chk("first_p44", int'(pw[24]), 8'h24);
        chk("first_p04", int'(pw[4]), 8'h04);
        chk("first_p40", int'(pw[20]), 8'h20);
      end
      if (hand == 1 && r == 4 && c == 3) chk("early_en", int'(o_enable_5x5), 0);
      if (hand == 1 && r == 7 && c == 7) chk("last_p44", int'(pw[24]), 8'h3F);
      if (hand == 2 && r == 5 && c == 6) begin
        chk("gap_en", int'(o_enable_5x5), 1);
        chk("gap_p44", int'(pw[24]), 8'h2E);
        chk("gap_p00", int'(pw[0]), 8'h0A);
      end
    end
  endtask

  initial begin
    int base;
    #2;
    chk("reset_en", int'(o_enable_5x5), 0);
    chk("reset_win_or", int'(|pw), 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    idle(2);

    base = en_seen;
    frame(0, 1'b1, 64, 1);
    idle(1);
    chk("frameA_enables", en_seen - base, 16);

    base = en_seen;
    frame(0, 1'b1, 64, 2);
    idle(1);
    chk("frameB_enables", en_seen - base, 16);

    frame(8'h80, 1'b1, 51, 0);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #2;
    chk("midreset_en", int'(o_enable_5x5), 0);
    chk("midreset_win_or", int'(|pw), 0);
    @(posedge i_clk);
    #1;
    chk("midreset_hold_or", int'(|pw), 0);
    i_rst_n = 1'b1;
    idle(1);
    base = en_seen;
    frame(8'h40, 1'b0, 64, 0);
    idle(1);
    chk("frameE_enables", en_seen - base, 16);

    frame(8'h10, 1'b1, 42, 0);
    base = en_seen;
    frame(8'h20, 1'b1, 36, 0);
    idle(1);
    chk("sof_restart_no_en", en_seen - base, 0);
    base = en_seen;
    for (int k = 36; k < 64; k++) send(k / 8, k % 8, 1'b0, 8'h20);
    idle(1);
    chk("sof_restart_enables", en_seen - base, 16);

    idle(3);
    chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_buffer_5x5.md
WINDOW_BUFFER_5X5 -- requirements
Module: window_buffer_5x5

Interface
REQ-001 SHALL have parameter WIDTH, default 8; bits per pixel.
REQ-002 SHALL have parameter IMG_WIDTH, default 64; pixels per row, minimum 5.
REQ-003 SHALL have parameter IMG_HEIGHT, default 64; rows per frame, minimum 5.
REQ-004 SHALL have port i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_valid  in  1  i_pixel accepted this cycle.
REQ-007 SHALL have port i_sof  in  1  start of frame, qualified by i_valid.
REQ-008 SHALL have port i_pixel  in  WIDTH  raster-order input pixel.
REQ-009 SHALL have ports o_pixel_00 .. o_pixel_44  out  WIDTH each  5x5 window; row r, column c.
REQ-010 SHALL have port o_enable_5x5  out  1  window complete and valid this cycle; drives the median filter enable.
REQ-011 SHALL have port o_frame_done  out  1  last-pixel pulse, present only when the macro in REQ-026 is defined.

Function
REQ-012 SHALL hold col counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1), both advancing only on i_valid=1.
REQ-013 SHALL, on acceptance at col=IMG_WIDTH-1, set col to 0 and increment row; at row=IMG_HEIGHT-1 as well, set row to 0.
REQ-014 SHALL keep four line buffers, each IMG_WIDTH deep, addressed by col, giving pixels from 1..4 rows earlier at the same column; read-before-write at the same address in the same cycle.
REQ-015 SHALL shift window left by one column per accepted pixel; the new column 4 is rows 0..3 from line buffers 4..1 rows back, row 4 from i_pixel.
REQ-016 SHALL make the window hold pixels (r-4..r, c-4..c) one cycle after accepting pixel (r,c); o_pixel_rc maps to image (r-4+row, c-4+col).
REQ-017 SHALL assert o_enable_5x5 for exactly one cycle, one cycle after accepting a pixel with row>=4 and col>=4; otherwise 0.
REQ-018 SHALL, while i_valid=0, hold window, counters and line buffers unchanged and drive o_enable_5x5=0.
REQ-019 SHALL never assert o_enable_5x5 for a window straddling a row wrap; REQ-017 guarantees this.
REQ-020 SHALL implement FSM states S_IDLE, S_FILL and S_RUN: S_IDLE->S_FILL on the first accepted pixel; S_FILL->S_RUN on accepting (3, IMG_WIDTH-1); S_RUN->S_FILL on accepting the last frame pixel; o_enable_5x5 is only possible in S_RUN.
REQ-021 SHALL, on i_valid=1 with i_sof=1, treat i_pixel as pixel (0,0) regardless of counters and enter S_FILL; stale line-buffer data is never exposed per REQ-017.
REQ-022 SHALL ignore i_sof when i_valid=0.
REQ-023 SHALL produce 25 window outputs that are register outputs, with no combinational path from the inputs.

Reset
REQ-024 SHALL, on i_rst_n=0, asynchronously clear counters to 0, window registers to 0, o_enable_5x5 and o_frame_done to 0, and set the FSM to S_IDLE; line-buffer contents are not reset.
REQ-025 SHALL, after reset release mid-frame, accept the next pixel as (0,0) even without i_sof.

Configuration
REQ-026 SHALL, with macro WINDOW_BUFFER_FRAME_DONE_EN defined, provide o_frame_done, asserted one cycle after accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1), concurrent with that window's o_enable_5x5.
REQ-027 SHALL, without WINDOW_BUFFER_FRAME_DONE_EN, omit the o_frame_done port and logic, leaving all other behaviour identical.

Verification
REQ-028 SHALL cover: IMG 8x8, pixel=r*8+c, i_sof on the first pixel -> first o_enable_5x5 one cycle after accepting (4,4); o_pixel_00=0x00, o_pixel_44=0x24, o_pixel_04=0x04, o_pixel_40=0x20.
REQ-029 SHALL cover: same 8x8 frame, continuous i_valid -> exactly 16 o_enable_5x5 pulses per frame, last window o_pixel_44=0x3F.
REQ-030 SHALL cover: i_valid low 3 cycles before pixel (5,6) -> no enable during the gap; window after (5,6) has o_pixel_44=0x2E, o_pixel_00=0x0A.
REQ-031 SHALL cover: i_rst_n pulsed low at pixel (6,3), then a new frame -> all outputs 0 during reset; no enable until (4,4) of the new frame.
REQ-032 SHALL cover: i_sof with i_valid at counter position (5,2) -> counters restart; no enable for the next 36 accepted pixels; enable on the 37th.
REQ-033 SHALL cover: WINDOW_BUFFER_FRAME_DONE_EN defined -> o_frame_done high for exactly one cycle, coincident with the enable for window ending (7,7), once per frame.
